seq_detect_param: RTL and testbench

Parametrised serial bit-sequence detector, the successor to the fixed-pattern `sequence_analyse` FSM. It samples a 1-bit serial stream under a valid qualifier and compares it against a runtime-loadable pattern of 1..PAT_LEN bits. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It sits between the serial input conditioning logic and the status/report logic of the lab design.

---
 rtl/seq_pkg.sv | 27 ++
 rtl/sat_counter.sv | 38 +++
 rtl/seq_detect_param.sv | 111 +++++++++++
 tb/tb_seq_detect_param.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants and helpers for the serial sequence detector and the
// other counters of the lab design.
package seq_pkg;

    // Pattern width used by the default detector build.
    localparam int SEQ_PAT_LEN = 8;

    // Width needed to hold a pattern length of 0..SEQ_PAT_LEN.
    localparam int LEN_W = $clog2(SEQ_PAT_LEN + 1);

    // Pattern and length loaded at reset (right-aligned, first bit in MSB of window).
    localparam logic [SEQ_PAT_LEN-1:0] SEQ_DEF_PAT = 8'b0000_1011;
    localparam int                     SEQ_DEF_LEN = 4;

    // Saturating increment: returns value+1, but never exceeds max_val.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_val);
        logic [31:0] result;
        if (value >= max_val) begin
            result = max_val;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a synchronous clear. A clear that coincides
// with an increment leaves the count at 1 so that the event is not lost.
module sat_counter
    import seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_nx;

    // Next count: clear wins, but keeps the coincident increment.
    always_comb begin
        count_nx = count;
        if (clr) begin
            count_nx = inc ? CNT_W'(1) : '0;
        end else if (inc) begin
            count_nx = CNT_W'(sat_inc(32'(count), 32'(CNT_MAX)));
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_nx;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial bit-sequence detector.
//
// Bits are accepted when in_valid is high and no configuration load is in
// progress. The newest bit enters hist[0]; a match is declared when at least
// len_q bits have been accepted since the last clear and the newest len_q bits
// equal pat_q[len_q-1:0] (pat_q[len_q-1] being the oldest bit of the window).
// In non-overlapping mode the fill level is reset on a match so no bit of the
// matched window can take part in the next match. match and cfg_err are
// registered pulses, visible for the cycle after the deciding edge.
module seq_detect_param
    import seq_pkg::*;
#(
    parameter int                   PAT_LEN = SEQ_PAT_LEN,
    parameter int                   CNT_W   = 8,
    parameter logic [PAT_LEN-1:0]   DEF_PAT = PAT_LEN'(SEQ_DEF_PAT),
    parameter int                   DEF_LEN = SEQ_DEF_LEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in,
    input  logic                         in_valid,
    input  logic                         overlap,
    input  logic                         cfg_load,
    input  logic [PAT_LEN-1:0]           cfg_pat,
    input  logic [$clog2(PAT_LEN+1)-1:0] cfg_len,
    input  logic                         cnt_clr,
    output logic                         match,
    output logic [CNT_W-1:0]             match_count,
    output logic                         cfg_err
);

    localparam int LW = $clog2(PAT_LEN + 1);
    localparam logic [LW-1:0] FILL_MAX = LW'(PAT_LEN);

    // Detector state.
    logic [PAT_LEN-1:0] hist;
    logic [LW-1:0]      fill;
    logic [PAT_LEN-1:0] pat_q;
    logic [LW-1:0]      len_q;

    // Combinational view of the candidate next state.
    logic               accept;
    logic               load_ok;
    logic [PAT_LEN-1:0] hist_nx;
    logic [LW-1:0]      fill_inc;
    logic [PAT_LEN-1:0] len_mask;
    logic [PAT_LEN-1:0] window_diff;
    logic               hit;

    // Decode the accepted bit, the load validity and the match condition.
    always_comb begin
        accept   = in_valid && !cfg_load;
        load_ok  = cfg_load && (cfg_len != '0) && (cfg_len <= FILL_MAX);
        hist_nx  = {hist[PAT_LEN-2:0], in};
        fill_inc = (fill >= FILL_MAX) ? FILL_MAX : fill + LW'(1);
        len_mask = '0;
        for (int i = 0; i < PAT_LEN; i++) begin
            len_mask[i] = (LW'(i) < len_q);
        end
        // Bits above the active length are masked out of the comparison.
        window_diff = (hist_nx ^ pat_q) & len_mask;
        hit = accept && (fill_inc >= len_q) && (window_diff == '0);
    end

    // History, fill level and active configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist  <= '0;
            fill  <= '0;
            pat_q <= DEF_PAT;
            len_q <= LW'(DEF_LEN);
        end else if (cfg_load) begin
            // A rejected load leaves both configuration and history untouched.
            if (load_ok) begin
                pat_q <= cfg_pat;
                len_q <= cfg_len;
                hist  <= '0;
                fill  <= '0;
            end
        end else if (in_valid) begin
            hist <= hist_nx;
            if (hit && !overlap) begin
                fill <= '0;
            end else begin
                fill <= fill_inc;
            end
        end
    end

    // Registered match and configuration-error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match   <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            match   <= hit;
            cfg_err <= cfg_load && !load_ok;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit),
        .clr   (cnt_clr),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus random traffic, with a
// per-cycle expected-output queue filled by the driver from a bit-queue model
// and drained by an independent monitor.
module tb_seq_detect_param;

    localparam int PAT_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int EXP_W   = CNT_W + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               in_bit   = 1'b0;
    logic               in_valid = 1'b0;
    logic               overlap  = 1'b0;
    logic               cfg_load = 1'b0;
    logic [PAT_LEN-1:0] cfg_pat  = '0;
    logic [LEN_W-1:0]   cfg_len  = '0;
    logic               cnt_clr  = 1'b0;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    seq_detect_param #(
        .PAT_LEN (PAT_LEN),
        .CNT_W   (CNT_W),
        .DEF_PAT (8'b0000_1011),
        .DEF_LEN (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in_bit),
        .in_valid    (in_valid),
        .overlap     (overlap),
        .cfg_load    (cfg_load),
        .cfg_pat     (cfg_pat),
        .cfg_len     (cfg_len),
        .cnt_clr     (cnt_clr),
        .match       (match),
        .match_count (match_count),
        .cfg_err     (cfg_err)
    );

    // ---------------- reference model ----------------
    int          m_bits[$];   // accepted bits since last clear, oldest first
    logic [7:0]  m_pat;
    int          m_len;
    int          m_count;

    logic [EXP_W-1:0] exp_q[$];   // {match, cfg_err, count} per cycle

    int n_checks = 0;
    int n_fail   = 0;
    int match_seen = 0;
    int err_seen   = 0;

    task automatic model_reset();
        m_bits.delete();
        m_pat   = 8'b0000_1011;
        m_len   = 4;
        m_count = 0;
    endtask

    task automatic check_val(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // ---------------- driver ----------------
    // Called half a cycle after an edge; applies inputs, predicts the outputs
    // seen after the coming edge, and advances to the same phase of the next cycle.
    task automatic drive(input logic b, input logic v, input logic ov,
                         input logic ld, input logic [7:0] p,
                         input logic [LEN_W-1:0] l, input logic clr);
        logic hit;
        logic err;
        hit = 1'b0;
        err = 1'b0;
        in_bit = b; in_valid = v; overlap = ov;
        cfg_load = ld; cfg_pat = p; cfg_len = l; cnt_clr = clr;
        if (ld) begin
            if (int'(l) >= 1 && int'(l) <= PAT_LEN) begin
                m_pat = p;
                m_len = int'(l);
                m_bits.delete();
            end else begin
                err = 1'b1;
            end
        end else if (v) begin
            m_bits.push_back(int'(b));
            if (m_bits.size() > PAT_LEN) void'(m_bits.pop_front());
            if (m_bits.size() >= m_len) begin
                hit = 1'b1;
                for (int k = 0; k < m_len; k++) begin
                    if (m_bits[m_bits.size() - 1 - k] != int'(m_pat[k])) hit = 1'b0;
                end
            end
            if (hit && !ov) m_bits.delete();
        end
        if (clr) m_count = hit ? 1 : 0;
        else if (hit && m_count < CNT_MAX) m_count++;
        exp_q.push_back({hit, err, CNT_W'(m_count)});
        @(posedge clk);
        #2;
    endtask

    task automatic feed(input logic b, input logic ov);
        drive(b, 1'b1, ov, 1'b0, 8'h00, '0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, '0, 1'b0);
    endtask

    task automatic load(input logic [7:0] p, input logic [LEN_W-1:0] l);
        drive(1'b0, 1'b0, 1'b0, 1'b1, p, l, 1'b0);
    endtask

    task automatic clear_count();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, '0, 1'b1);
    endtask

    task automatic feed_seq(input logic [15:0] bits, input int n, input logic ov);
        for (int i = n - 1; i >= 0; i--) feed(bits[i], ov);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (match === 1'b1) match_seen++;
            if (cfg_err === 1'b1) err_seen++;
            if (exp_q.size() > 0) begin
                logic [EXP_W-1:0] e;
                logic [EXP_W-1:0] g;
                e = exp_q.pop_front();
                g = {match, cfg_err, match_count};
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL outputs at %0t: got match=%0b err=%0b count=%0d, expected match=%0b err=%0b count=%0d",
                             $time, g[EXP_W-1], g[EXP_W-2], g[CNT_W-1:0],
                             e[EXP_W-1], e[EXP_W-2], e[CNT_W-1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int base_m;
    int base_e;

    initial begin
        model_reset();
        #3;
        check_val("reset match", int'(match), 0);
        check_val("reset cfg_err", int'(cfg_err), 0);
        check_val("reset count", int'(match_count), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Default pattern 1011, overlapping.
        base_m = match_seen;
        feed_seq(16'b1011011, 7, 1'b1);
        check_val("default overlap matches", match_seen - base_m, 2);
        check_val("default overlap count", int'(match_count), 2);

        // Same stream, non-overlapping, from a fresh history.
        clear_count();
        load(8'b0000_1011, 4'd4);
        base_m = match_seen;
        feed_seq(16'b1011011, 7, 1'b0);
        check_val("default no-overlap matches", match_seen - base_m, 1);
        check_val("default no-overlap count", int'(match_count), 1);

        // Pattern 11, length 2.
        load(8'b0000_0011, 4'd2);
        base_m = match_seen;
        feed_seq(16'b1111, 4, 1'b1);
        check_val("len2 overlap matches", match_seen - base_m, 3);
        load(8'b0000_0011, 4'd2);
        base_m = match_seen;
        feed_seq(16'b1111, 4, 1'b0);
        check_val("len2 no-overlap matches", match_seen - base_m, 2);

        // Rejected loads keep the configuration.
        load(8'b0000_1011, 4'd4);
        base_e = err_seen;
        load(8'hFF, 4'd0);
        load(8'hFF, 4'd9);
        check_val("rejected loads", err_seen - base_e, 2);
        base_m = match_seen;
        feed_seq(16'b1011, 4, 1'b1);
        check_val("pattern kept after rejects", match_seen - base_m, 1);

        // Gaps in in_valid.
        load(8'b0000_1011, 4'd4);
        base_m = match_seen;
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] s;
            s = 4'b1011;
            feed(s[i], 1'b1);
            if (i != 0) repeat (3) idle();
        end
        check_val("gapped matches", match_seen - base_m, 1);

        // Load on the completing bit discards it.
        base_m = match_seen;
        feed_seq(16'b101, 3, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'b0000_1011, 4'd4, 1'b0);
        check_val("load blocks match", match_seen - base_m, 0);

        // Saturation and clear-with-match.
        clear_count();
        load(8'b0000_0001, 4'd1);
        feed_seq(16'b11111, 5, 1'b1);
        check_val("saturated count", int'(match_count), CNT_MAX);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, '0, 1'b1);
        check_val("clear with match", int'(match_count), 1);

        // Asynchronous reset mid-sequence.
        load(8'b0000_1011, 4'd4);
        feed_seq(16'b101, 3, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check_val("async reset match", int'(match), 0);
        check_val("async reset count", int'(match_count), 0);
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        base_m = match_seen;
        feed(1'b1, 1'b1);
        check_val("no match after reset", match_seen - base_m, 0);
        check_val("outputs after reset", int'({match, cfg_err, match_count}), 0);

        // Random traffic.
        for (int c = 0; c < 800; c++) begin
            logic             b, v, ov, ld, clr;
            logic [7:0]       p;
            logic [LEN_W-1:0] l;
            b   = 1'($urandom_range(0, 1));
            v   = ($urandom_range(0, 3) != 0);
            ov  = 1'($urandom_range(0, 1));
            ld  = ($urandom_range(0, 24) == 0);
            clr = ($urandom_range(0, 30) == 0);
            p   = 8'($urandom_range(0, 255));
            l   = ($urandom_range(0, 2) == 0) ? LEN_W'($urandom_range(0, 15))
                                              : LEN_W'($urandom_range(1, 3));
            drive(b, v, ov, ld, p, l, clr);
        end

        idle();
        idle();
        check_val("scoreboard drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
